fifo_uart_tx: RTL and testbench

//   Drain stage that sits directly downstream of the 8-bit Buffer FIFO.

---
 rtl/fifo_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit buffer FIFO one byte at a time and serializes
// each byte as an asynchronous UART frame (start, DATA_WIDTH bits LSB first,
// optional even parity, one stop bit). The line idles high.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    tx_d, read_d, busy_d;
  logic                    bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  // Even parity: XOR of all payload bits.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state, counter and shift-register update, plus the output levels
  // for the upcoming cycle (decoded from the next state so outputs register).
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) state_d = POP;
      end
      POP: state_d = LOAD;
      LOAD: begin
        shreg_d = fifo_data;
`ifdef UART_TX_PARITY_EN
        par_d   = even_parity(fifo_data);
`endif
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    tx_d   = 1'b1;
    read_d = (state_d == POP);
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      tx        <= 1'b1;
      fifo_read <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      tx        <= tx_d;
      fifo_read <= read_d;
      busy      <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the byte in flight, captured alongside the shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: a queue-backed FIFO model feeds the DUT, a
// scoreboard queue holds the bytes each frame must carry, and a monitor
// decodes the serial line cycle by cycle.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty = 1'b1;
  logic [7:0]   fifo_data  = 8'h00;
  logic         fifo_read;
  logic         tx;
  logic         busy;

  logic [7:0]   src[$];
  logic [7:0]   exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           pushed = 0;
  int           pops = 0;
  int           frames = 0;
  int           aborted = 0;
  bit           mon_in_frame = 1'b0;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop request.
  always @(posedge clk) begin
    if (fifo_read && src.size() != 0) begin
      fifo_data <= src.pop_front();
      pops      <= pops + 1;
    end
    fifo_empty <= (src.size() == 0);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    src.push_back(b);
    exp_q.push_back(b);
    pushed++;
  endtask

  // Expected line level for frame bit index bi of byte b.
  function automatic logic frame_level(input logic [7:0] b, input int bi);
    if (bi == 0) return 1'b0;
    if (bi <= DW) return b[bi-1];
`ifdef UART_TX_PARITY_EN
    if (bi == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((src.size() != 0 || exp_q.size() != 0 || mon_in_frame || busy) && n < 5000);
    chk({"idle_reached_", tag}, int'(n < 5000), 1);
    repeat (2) @(negedge clk);
  endtask

  // Per-cycle handshake and idle rules.
  initial begin : rules
    bit prev_read;
    prev_read = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_outputs", int'({tx, fifo_read, busy}), 4);
      end else begin
        if (fifo_read) begin
          chk("read_while_empty", int'(fifo_empty), 0);
          chk("read_pulse_width", int'(prev_read), 0);
        end
        if (!busy) chk("idle_line_high", int'(tx), 1);
      end
      prev_read = fifo_read;
    end
  end

  // Line monitor: decodes frames and compares against the scoreboard.
  initial begin : monitor
    int pos, run, mism, cyc, fall_cyc, bi;
    bit fall_valid, have_prev, avail, post_chk, prev_empty;
    logic [7:0] cur, got;
    pos = 0; run = 0; mism = 0; cyc = 0; fall_cyc = 0; bi = 0;
    fall_valid = 0; have_prev = 0; avail = 0; post_chk = 0; prev_empty = 1;
    cur = 8'h00; got = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (mon_in_frame) aborted++;
        mon_in_frame = 1'b0;
        have_prev = 0; fall_valid = 0; run = 0; post_chk = 0;
        prev_empty = fifo_empty;
        continue;
      end
      if (post_chk) begin
        chk("busy_after_stop", int'({busy, tx}), 1);
        post_chk = 0;
      end
      if (prev_empty && !fifo_empty && !busy) begin
        fall_valid = 1;
        fall_cyc   = cyc;
      end
      prev_empty = fifo_empty;
      if (!mon_in_frame) begin
        if (tx) begin
          run++;
        end else begin
          chk("frame_expected", int'(exp_q.size() != 0), 1);
          cur = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          if (fall_valid) chk("start_latency", cyc - fall_cyc, 3);
          fall_valid = 0;
          if (have_prev) begin
            if (avail) chk("b2b_gap", run + CPB, CPB + 3);
            else       chk("min_gap", int'(run + CPB >= CPB + 3), 1);
          end
          mon_in_frame = 1'b1;
          pos = 0; mism = 0; got = 8'h00;
        end
      end
      if (mon_in_frame) begin
        bi = pos / CPB;
        if (tx !== frame_level(cur, bi) || busy !== 1'b1) mism++;
        if (bi >= 1 && bi <= DW && (pos % CPB) == CPB / 2) got[bi-1] = tx;
        if (bi == NB - 1 && (pos % CPB) == 0) avail = !fifo_empty;
        pos++;
        if (pos == NB * CPB) begin
          chk("frame_byte", int'(got), int'(cur));
          chk("frame_shape_bad_cycles", mism, 0);
          frames++;
          mon_in_frame = 1'b0;
          have_prev = 1; run = 0; post_chk = 1;
        end
      end
    end
  end

  // Stimulus.
  initial begin : stim
    int n;
    rst = 1'b0;
    push(8'h3C);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", int'({tx, fifo_read, busy}), 4);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_idle("after_reset");

    repeat (100) begin
      @(negedge clk);
      chk("empty_idle", int'({tx, fifo_read, busy}), 4);
    end

    push(8'hA5);
    wait_idle("single");

    push(8'h01); push(8'h02); push(8'h03);
    wait_idle("burst3");

    // Reset in the middle of data bit 3 of 0x0F.
    push(8'h0F);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 50);
    chk("start_seen_0f", int'(n < 50), 1);
    repeat (17) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset", int'({tx, fifo_read, busy}), 4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_reset_idle", int'({tx, fifo_read, busy}), 4);
    end
    push(8'h5A);
    wait_idle("after_midframe_reset");

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    wait_idle("parity_07");
    push(8'h03);
    wait_idle("parity_03");
`endif

    for (int it = 0; it < 30; it++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) push(8'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle("random");

    chk("pop_count", pops, pushed);
    chk("frames_accounted", frames + aborted, pushed);
    chk("aborted_frames", aborted, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
